lc3b_memory: RTL and testbench

//   Multi-cycle memory responder that consumes the effective addresses the

---
 rtl/lc3b_memory_if.sv | 31 +++
 rtl/lc3b_memory.sv | 99 +++++++++
 tb/tb_lc3b_memory.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/lc3b_memory_if.sv
// LC-3b memory bus: request strobe and attributes from the datapath/microsequencer
// (master) to the memory responder (slave). The responder returns read data,
// the one-cycle ready pulse and the alignment-error flag.
//   MIO_EN    master->slave  request strobe
//   R_W       master->slave  0 = read, 1 = write
//   DATA_SIZE master->slave  0 = byte, 1 = word
//   ADDR      master->slave  byte address (MAR)
//   WDATA     master->slave  write data (MDR)
//   RDATA     slave->master  full aligned read word
//   R         slave->master  ready, one cycle per request
//   ALIGN_ERR slave->master  misaligned word access, valid with R
interface lc3b_memory_if;
   logic        MIO_EN;
   logic        R_W;
   logic        DATA_SIZE;
   logic [15:0] ADDR;
   logic [15:0] WDATA;
   logic [15:0] RDATA;
   logic        R;
   logic        ALIGN_ERR;

   modport master (
      output MIO_EN, R_W, DATA_SIZE, ADDR, WDATA,
      input  RDATA, R, ALIGN_ERR
   );

   modport slave (
      input  MIO_EN, R_W, DATA_SIZE, ADDR, WDATA,
      output RDATA, R, ALIGN_ERR
   );
endinterface

// File: rtl/lc3b_memory.sv
// Multi-cycle LC-3b memory responder. One request is accepted at a time when
// MIO_EN is high in IDLE; after LATENCY clocks R pulses for one cycle, and the
// same edge that raises R commits a write or loads RDATA.
//   CLK    clock, rising edge
//   RESET  synchronous active-high reset (control and output registers only;
//          the memory array is not cleared)
//   bus    lc3b_memory_if slave modport (MIO_EN/R_W/DATA_SIZE/ADDR/WDATA in,
//          RDATA/R/ALIGN_ERR out)
module lc3b_memory #(
   parameter int ADDR_W  = 15,
   parameter int LATENCY = 5
) (
   input  logic         CLK,
   input  logic         RESET,
   lc3b_memory_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   state_t            state_q;
   logic [3:0]        cnt_q;
   logic              r_w_q;
   logic              size_q;
   logic [15:0]       addr_q;
   logic [15:0]       wdata_q;
   logic [15:0]       rdata_q;
   logic              r_q;
   logic              err_q;
   logic [15:0]       mem_q [0:(1<<ADDR_W)-1];

   logic [ADDR_W-1:0] idx;
   logic              misalign;
   logic              we;
   logic              lo_en;
   logic              hi_en;

   // Address bits above ADDR_W are dropped, so accesses wrap modulo the array.
   assign idx      = addr_q[ADDR_W:1];
   assign misalign = size_q & addr_q[0];
   // DONE is the cycle before R is seen; leaving it commits the access.
   // A reset on that edge aborts the write.
   assign we       = (state_q == DONE) & ~RESET & r_w_q & ~misalign;
   assign lo_en    = size_q | ~addr_q[0];
   assign hi_en    = size_q |  addr_q[0];

   assign bus.RDATA     = rdata_q;
   assign bus.R         = r_q;
   assign bus.ALIGN_ERR = err_q;

   // Control FSM and registered outputs
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         r_q     <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 16'h0000;
      end else begin
         r_q   <= 1'b0;
         err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.MIO_EN) begin
                  cnt_q   <= 4'(LATENCY - 1);
                  state_q <= (LATENCY == 1) ? DONE : BUSY;
               end
            end
            BUSY: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_q <= DONE;
            end
            DONE: begin
               r_q   <= 1'b1;
               err_q <= misalign;
               if (!r_w_q) rdata_q <= mem_q[idx];
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Request capture: only the copy taken at the accepting edge is used later
   always_ff @(posedge CLK) begin
      if (state_q == IDLE && bus.MIO_EN) begin
         r_w_q   <= bus.R_W;
         size_q  <= bus.DATA_SIZE;
         addr_q  <= bus.ADDR;
         wdata_q <= bus.WDATA;
      end
   end

   // Storage array with per-byte lane enables
   always_ff @(posedge CLK) begin
      if (we) begin
         if (lo_en) mem_q[idx][7:0]  <= wdata_q[7:0];
         if (hi_en) mem_q[idx][15:8] <= wdata_q[15:8];
      end
   end
endmodule

// File: tb/tb_lc3b_memory.sv
module tb_lc3b_memory;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lc3b_memory_if bus5();
   lc3b_memory_if bus1();

   lc3b_memory #(.ADDR_W(15), .LATENCY(5)) u5 (.CLK(clk), .RESET(rst), .bus(bus5));
   lc3b_memory #(.ADDR_W(15), .LATENCY(1)) u1 (.CLK(clk), .RESET(rst), .bus(bus1));

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        rw;
      logic        sz;
      logic [15:0] a;
      logic [15:0] wd;
      logic        err;
      logic [15:0] rd;
   } vec_t;

   vec_t v[15];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input int sel, input logic en, input logic rw, input logic sz,
                        input logic [15:0] a, input logic [15:0] wd);
      if (sel == 0) begin
         bus5.MIO_EN = en; bus5.R_W = rw; bus5.DATA_SIZE = sz; bus5.ADDR = a; bus5.WDATA = wd;
      end else begin
         bus1.MIO_EN = en; bus1.R_W = rw; bus1.DATA_SIZE = sz; bus1.ADDR = a; bus1.WDATA = wd;
      end
   endtask

   function automatic logic get_r(input int sel);
      return (sel == 0) ? bus5.R : bus1.R;
   endfunction

   function automatic logic get_err(input int sel);
      return (sel == 0) ? bus5.ALIGN_ERR : bus1.ALIGN_ERR;
   endfunction

   function automatic logic [15:0] get_rd(input int sel);
      return (sel == 0) ? bus5.RDATA : bus1.RDATA;
   endfunction

   // One request; after acceptance the inputs are scrambled to show only the
   // latched copy matters. lat = edges from accept to R (99 if it never came).
   task automatic do_req(input int sel, input logic rw, input logic sz,
                         input logic [15:0] a, input logic [15:0] wd, output int lat);
      int k;
      lat = 99;
      k = 0;
      @(negedge clk);
      drive(sel, 1'b1, rw, sz, a, wd);
      @(posedge clk);
      #1 drive(sel, 1'b0, ~rw, ~sz, ~a, ~wd);
      while (lat == 99 && k < 20) begin
         k++;
         @(posedge clk);
         #1;
         if (get_r(sel)) lat = k;
      end
   endtask

   // MIO_EN held high: write/read/write/read with garbage writes presented
   // during every non-accepting cycle.
   task automatic b2b(input int sel, input int lat);
      int p, q, qq;
      logic exp_r;
      logic [15:0] a, wd;
      p = lat + 1;
      for (int e = 0; e < 4 * p; e++) begin
         q = e / p;
         @(negedge clk);
         if (e % p == 0) begin
            a  = (q < 2) ? 16'h7000 : 16'h7002;
            wd = (q < 2) ? 16'h1111 : 16'h2222;
            drive(sel, 1'b1, (q % 2 == 0), 1'b1, a, wd);
         end else begin
            drive(sel, 1'b1, 1'b1, 1'b1, 16'h7000, 16'hDEAD);
         end
         @(posedge clk);
         #1;
         exp_r = (e >= lat) && ((e - lat) % p == 0);
         chk("b2b_r", {63'd0, get_r(sel)}, {63'd0, exp_r});
         if (exp_r) begin
            qq = (e - lat) / p;
            if (qq % 2 == 1)
               chk("b2b_rdata", {48'd0, get_rd(sel)}, (qq == 1) ? 64'h1111 : 64'h2222);
         end
      end
      @(negedge clk);
      drive(sel, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
   endtask

   initial begin
      int lat;
      int rcount;

      v[0]  = '{1'b1, 1'b1, 16'h3000, 16'hBEEF, 1'b0, 16'h0000};
      v[1]  = '{1'b0, 1'b1, 16'h3000, 16'h0000, 1'b0, 16'hBEEF};
      v[2]  = '{1'b1, 1'b1, 16'h4000, 16'h1234, 1'b0, 16'hBEEF};
      v[3]  = '{1'b1, 1'b0, 16'h4001, 16'hABAB, 1'b0, 16'hBEEF};
      v[4]  = '{1'b0, 1'b1, 16'h4000, 16'h0000, 1'b0, 16'hAB34};
      v[5]  = '{1'b1, 1'b0, 16'h4000, 16'hCDCD, 1'b0, 16'hAB34};
      v[6]  = '{1'b0, 1'b0, 16'h4000, 16'h0000, 1'b0, 16'hABCD};
      v[7]  = '{1'b1, 1'b1, 16'h5000, 16'h0000, 1'b0, 16'hABCD};
      v[8]  = '{1'b1, 1'b1, 16'h5001, 16'h5555, 1'b1, 16'hABCD};
      v[9]  = '{1'b0, 1'b1, 16'h5000, 16'h0000, 1'b0, 16'h0000};
      v[10] = '{1'b0, 1'b1, 16'h5001, 16'h0000, 1'b1, 16'h0000};
      v[11] = '{1'b0, 1'b0, 16'h5001, 16'h0000, 1'b0, 16'h0000};
      v[12] = '{1'b1, 1'b1, 16'h6000, 16'h0F0F, 1'b0, 16'h0000};
      v[13] = '{1'b1, 1'b0, 16'h5001, 16'h7777, 1'b0, 16'h0000};
      v[14] = '{1'b0, 1'b0, 16'h5000, 16'h0000, 1'b0, 16'h7700};

      rst = 1'b1;
      drive(0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      drive(1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      // Idle after reset
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         chk("idle", {bus5.R, bus5.ALIGN_ERR, bus5.RDATA, bus1.R, bus1.ALIGN_ERR, bus1.RDATA}, 64'd0);
      end

      // Directed vector table, LATENCY=5
      for (int i = 0; i < 15; i++) begin
         do_req(0, v[i].rw, v[i].sz, v[i].a, v[i].wd, lat);
         chk($sformatf("v%0d_lat", i), lat, 5);
         chk($sformatf("v%0d_err", i), {63'd0, get_err(0)}, {63'd0, v[i].err});
         chk($sformatf("v%0d_rdata", i), {48'd0, get_rd(0)}, {48'd0, v[i].rd});
      end

      // Continuous MIO_EN, LATENCY=5
      b2b(0, 5);

      // Reset two edges into a write of FFFF over 0F0F at 6000
      @(negedge clk);
      drive(0, 1'b1, 1'b1, 1'b1, 16'h6000, 16'hFFFF);
      @(posedge clk);
      #1 drive(0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      rcount = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (bus5.R) rcount++;
      end
      chk("abort_no_r", rcount, 0);
      chk("abort_rdata_rst", {48'd0, bus5.RDATA}, 64'h0);
      do_req(0, 1'b0, 1'b1, 16'h6000, 16'h0000, lat);
      chk("abort_read_lat", lat, 5);
      chk("abort_read_rdata", {48'd0, bus5.RDATA}, 64'h0F0F);

      // LATENCY=1 instance
      do_req(1, 1'b1, 1'b1, 16'h3000, 16'hBEEF, lat);
      chk("l1_w_lat", lat, 1);
      chk("l1_w_rdata", {48'd0, bus1.RDATA}, 64'h0);
      do_req(1, 1'b0, 1'b1, 16'h3000, 16'h0000, lat);
      chk("l1_r_lat", lat, 1);
      chk("l1_r_rdata", {48'd0, bus1.RDATA}, 64'hBEEF);
      b2b(1, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
